// File: rtl/dequant_sched.sv
// Scheduler for the shared dequantize unit: looks up per-channel scales, issues words,
// tracks them through the unit's fixed latency and returns results through a credit-checked FIFO.
module dequant_sched #(
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 16,
  parameter int CH_W       = $clog2(NUM_CH),
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_addr,
  input  logic [DATA_W-1:0] cfg_scale,
  input  logic              start,
  input  logic [LEN_W-1:0]  job_len,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  output logic              dq_en,
  output logic [DATA_W-1:0] dq_data_in,
  output logic [DATA_W-1:0] dq_scale,
  input  logic [DATA_W-1:0] dq_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch
);
  // state | meaning
  // IDLE  | waiting for start, scale table writable
  // RUN   | accepting and issuing words
  // DRAIN | all words issued, waiting for unit and FIFO to empty
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Stage 0 sits beside dq_data_in; stages 1..LAT+1 follow the unit from its sample edge to its result.
  localparam int PIPE  = LAT + 2;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + PIPE + 1) + 1;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_q, issued;
  logic [DATA_W-1:0] tbl [NUM_CH];
  logic [PIPE-1:0]   vp;
  logic [CH_W-1:0]   cp [PIPE];
  logic [DATA_W-1:0] fifo_d [FIFO_DEPTH];
  logic [CH_W-1:0]   fifo_c [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_count, inflight;
  logic              accept, push, pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE; i++) inflight = inflight + CNT_W'(vp[i]);
  end

  assign accept    = in_valid && in_ready;
  assign push      = vp[PIPE-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_d[rd_ptr];
  assign out_ch    = fifo_c[rd_ptr];

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    dq_en     = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (job_len == '0) ? DONE : RUN;
      RUN: begin
        busy     = 1'b1;
        dq_en    = 1'b1;
        // Credits count every accepted word not yet popped, so a push can never overflow.
        in_ready = (issued != len_q) && ((fifo_count + inflight) < CNT_W'(FIFO_DEPTH));
        if (issued == len_q) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy  = 1'b1;
        dq_en = 1'b1;
        if (inflight == '0 && fifo_count == '0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      issued     <= '0;
      dq_data_in <= '0;
      dq_scale   <= '0;
      vp         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < NUM_CH; i++) tbl[i] <= '0;
      for (int i = 0; i < PIPE; i++) cp[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_d[i] <= '0;
        fifo_c[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        len_q  <= job_len;
        issued <= '0;
      end else if (accept) begin
        issued <= issued + LEN_W'(1);
      end
      if (cfg_we && state == IDLE) tbl[cfg_addr] <= cfg_scale;
      dq_data_in <= accept ? in_data : '0;
      dq_scale   <= accept ? tbl[in_ch] : '0;
      vp         <= {vp[PIPE-2:0], accept};
      cp[0]      <= accept ? in_ch : '0;
      for (int i = 1; i < PIPE; i++) cp[i] <= cp[i-1];
      if (push) begin
        fifo_d[wr_ptr] <= dq_data_out;
        fifo_c[wr_ptr] <= cp[PIPE-1];
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule

// File: tb/tb_dequant_sched.sv
// Directed bench for dequant_sched with a behavioural model of the dequantize unit.
module tb_dequant_sched;
  localparam int DATA_W = 32, NUM_CH = 16, CH_W = 4, LAT = 4, FIFO_DEPTH = 8, LEN_W = 16;

  logic clk = 0, rst = 1;
  logic cfg_we = 0, start = 0, in_valid = 0, out_ready = 1;
  logic [CH_W-1:0] cfg_addr = '0, in_ch = '0, out_ch;
  logic [DATA_W-1:0] cfg_scale = '0, in_data = '0, dq_data_in, dq_scale, dq_data_out, out_data;
  logic [LEN_W-1:0] job_len = '0;
  logic busy, done, in_ready, dq_en, out_valid;

  dequant_sched #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .LAT(LAT),
                  .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale),
    .start(start), .job_len(job_len), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
    .dq_en(dq_en), .dq_data_in(dq_data_in), .dq_scale(dq_scale), .dq_data_out(dq_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch));

  always #5 clk = ~clk;

  // Unit model: samples its operands one edge after issue, result valid LAT edges later.
  logic [DATA_W-1:0] upipe [LAT+1];
  logic [DATA_W-1:0] prod;
  assign prod = DATA_W'($signed(dq_data_in) * $signed(dq_scale));
  always @(posedge clk) if (dq_en) begin
    upipe[0] <= prod;
    for (int i = 1; i <= LAT; i++) upipe[i] <= upipe[i-1];
  end
  assign dq_data_out = upipe[LAT];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, passed = 0;
  int n_acc, n_got, first_acc, first_val, first_pop, last_pop, done_cyc, acc_at_hold;
  logic ir_at_hold, done_seen;
  logic [DATA_W-1:0] vin [32], got_d [32], exp_d [32];
  logic [CH_W-1:0] vch [32], got_c [32], exp_c [32];
  int sc [4] = '{2, -1, 1000, -200};

  task automatic cfg_write(input int addr, input int val);
    @(negedge clk); cfg_we = 1; cfg_addr = CH_W'(addr); cfg_scale = DATA_W'(val);
    @(negedge clk); cfg_we = 0;
  endtask

  task automatic start_job(input int len);
    @(negedge clk); start = 1; job_len = LEN_W'(len);
    @(negedge clk); start = 0;
  endtask

  task automatic drive_job(input int n, input int hold);
    n_acc = 0; n_got = 0; first_acc = -1; first_val = -1; first_pop = -1; last_pop = -1;
    done_seen = 0; done_cyc = -1; acc_at_hold = -1; ir_at_hold = 1'b1;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      @(negedge clk);
      in_valid = (n_acc < n);
      in_data = vin[n_acc]; in_ch = vch[n_acc];
      out_ready = (c >= hold);
      #1;
      if (c == hold - 1) begin acc_at_hold = n_acc; ir_at_hold = in_ready; end
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc + 1;
        n_acc++;
      end
      if (out_valid && first_val < 0) first_val = cyc;
      if (out_valid && out_ready) begin
        if (n_got < 32) begin got_d[n_got] = out_data; got_c[n_got] = out_ch; end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        n_got++;
      end
      if (done) begin done_seen = 1; done_cyc = cyc; end
    end
    in_valid = 0; out_ready = 1;
    checks++;
    if (done_seen !== 1'b1) $display("FAIL job_done_timeout: done never seen, got %0d of %0d results", n_got, n);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    checks += 9;
    if (busy !== 0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    if (done !== 0) $display("FAIL rst_done: got %b want 0", done); else passed++;
    if (in_ready !== 0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else passed++;
    if (dq_en !== 0) $display("FAIL rst_dq_en: got %b want 0", dq_en); else passed++;
    if (out_valid !== 0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
    if (dq_data_in !== 0) $display("FAIL rst_dq_data_in: got %0d want 0", dq_data_in); else passed++;
    if (dq_scale !== 0) $display("FAIL rst_dq_scale: got %0d want 0", dq_scale); else passed++;
    if (out_data !== 0) $display("FAIL rst_out_data: got %0d want 0", out_data); else passed++;
    if (out_ch !== 0) $display("FAIL rst_out_ch: got %0d want 0", out_ch); else passed++;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_single();
    cfg_write(3, 5);
    vin[0] = 32'(-7); vch[0] = 4'd3;
    start_job(1);
    drive_job(1, 0);
    checks += 5;
    if (n_got !== 1) $display("FAIL t1_count: got %0d want 1", n_got); else passed++;
    if (got_d[0] !== 32'(-35)) $display("FAIL t1_data: got %0d want -35", $signed(got_d[0])); else passed++;
    if (got_c[0] !== 4'd3) $display("FAIL t1_ch: got %0d want 3", got_c[0]); else passed++;
    if (first_val !== first_acc + LAT + 2)
      $display("FAIL t1_latency: out_valid at %0d want %0d", first_val, first_acc + LAT + 2);
    else passed++;
    if (done_cyc !== last_pop + 2)
      $display("FAIL t1_done_timing: done at %0d want %0d", done_cyc, last_pop + 2);
    else passed++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) cfg_write(i, sc[i]);
    vin[0] = 32'd5;          vch[0] = 4'd0; exp_d[0] = 32'd10;
    vin[1] = 32'(-1000);     vch[1] = 4'd3; exp_d[1] = 32'd200000;
    vin[2] = 32'd7;          vch[2] = 4'd1; exp_d[2] = 32'(-7);
    vin[3] = 32'(-3);        vch[3] = 4'd2; exp_d[3] = 32'(-3000);
    vin[4] = 32'd123;        vch[4] = 4'd1; exp_d[4] = 32'(-123);
    vin[5] = 32'd100000;     vch[5] = 4'd0; exp_d[5] = 32'd200000;
    vin[6] = 32'(-2);        vch[6] = 4'd3; exp_d[6] = 32'd400;
    vin[7] = 32'h7fff_ffff;  vch[7] = 4'd0; exp_d[7] = 32'hffff_fffe;
    start_job(8);
    drive_job(8, 0);
    checks += 2;
    if (n_got !== 8) $display("FAIL t2_count: got %0d want 8", n_got); else passed++;
    if (last_pop - first_pop !== 7)
      $display("FAIL t2_bubbles: pop span %0d want 7", last_pop - first_pop);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      checks += 2;
      if (got_d[i] !== exp_d[i])
        $display("FAIL t2_data[%0d]: got %0d want %0d", i, $signed(got_d[i]), $signed(exp_d[i]));
      else passed++;
      if (got_c[i] !== vch[i]) $display("FAIL t2_ch[%0d]: got %0d want %0d", i, got_c[i], vch[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) begin
      vin[i] = 32'(i + 1); vch[i] = 4'(i % 4); exp_d[i] = 32'((i + 1) * sc[i % 4]);
    end
    start_job(16);
    drive_job(16, 30);
    checks += 3;
    if (acc_at_hold !== FIFO_DEPTH)
      $display("FAIL t3_credit_accepts: got %0d want %0d", acc_at_hold, FIFO_DEPTH);
    else passed++;
    if (ir_at_hold !== 1'b0) $display("FAIL t3_in_ready_stalled: got %b want 0", ir_at_hold); else passed++;
    if (n_got !== 16) $display("FAIL t3_count: got %0d want 16", n_got); else passed++;
    for (int i = 0; i < 16; i++) begin
      checks += 2;
      if (got_d[i] !== exp_d[i])
        $display("FAIL t3_data[%0d]: got %0d want %0d", i, $signed(got_d[i]), $signed(exp_d[i]));
      else passed++;
      if (got_c[i] !== vch[i]) $display("FAIL t3_ch[%0d]: got %0d want %0d", i, got_c[i], vch[i]);
      else passed++;
    end
  endtask

  task automatic test_zero_len_and_cfg();
    int nb, nd, nir;
    nb = 0; nd = 0; nir = 0;
    @(negedge clk); start = 1; job_len = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); start = 0;
      #1;
      nb += int'(busy); nd += int'(done); nir += int'(in_ready);
    end
    checks += 3;
    if (nb !== 1) $display("FAIL t4_busy_cycles: got %0d want 1", nb); else passed++;
    if (nd !== 1) $display("FAIL t4_done_pulses: got %0d want 1", nd); else passed++;
    if (nir !== 0) $display("FAIL t4_in_ready: got %0d cycles want 0", nir); else passed++;
    cfg_write(5, 7);
    cfg_write(6, 1);
    cfg_write(6, -4);
    vin[0] = 32'd3; vch[0] = 4'd5;
    vin[1] = 32'd10; vch[1] = 4'd6;
    start_job(2);
    @(negedge clk); cfg_we = 1; cfg_addr = 4'd5; cfg_scale = 32'd99;
    @(negedge clk); cfg_we = 0;
    drive_job(2, 0);
    checks += 2;
    if (got_d[0] !== 32'd21) $display("FAIL t4_cfg_busy_drop: got %0d want 21", $signed(got_d[0])); else passed++;
    if (got_d[1] !== 32'(-40)) $display("FAIL t4_last_write_wins: got %0d want -40", $signed(got_d[1])); else passed++;
    vin[0] = 32'd1; vch[0] = 4'd5;
    start_job(1);
    drive_job(1, 0);
    checks++;
    if (got_d[0] !== 32'd7) $display("FAIL t4_readback: got %0d want 7", $signed(got_d[0])); else passed++;
  endtask

  task automatic test_mid_reset();
    start_job(8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); in_valid = 1; in_data = 32'(i + 3); in_ch = 4'(i % 4); out_ready = 0;
    end
    @(negedge clk); in_valid = 0; rst = 1;
    @(negedge clk); rst = 0;
    #1;
    checks += 6;
    if (busy !== 0) $display("FAIL t5_busy: got %b want 0", busy); else passed++;
    if (done !== 0) $display("FAIL t5_done: got %b want 0", done); else passed++;
    if (out_valid !== 0) $display("FAIL t5_out_valid: got %b want 0", out_valid); else passed++;
    if (out_data !== 0) $display("FAIL t5_out_data: got %0d want 0", out_data); else passed++;
    if (dq_en !== 0) $display("FAIL t5_dq_en: got %b want 0", dq_en); else passed++;
    if (dq_scale !== 0) $display("FAIL t5_dq_scale: got %0d want 0", dq_scale); else passed++;
    out_ready = 1;
    cfg_write(0, 2);
    vin[0] = 32'd21; vch[0] = 4'd0;
    start_job(1);
    drive_job(1, 0);
    checks += 3;
    if (n_got !== 1) $display("FAIL t5_count: got %0d want 1", n_got); else passed++;
    if (got_d[0] !== 32'd42) $display("FAIL t5_data: got %0d want 42", $signed(got_d[0])); else passed++;
    if (got_c[0] !== 4'd0) $display("FAIL t5_ch: got %0d want 0", got_c[0]); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_zero_len_and_cfg();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
